// File: rtl/pipelined_regfile_alu.sv
// rtl/pipelined_regfile_alu.sv - register file feeding a two-stage ALU pipeline (EX, OUT)
// Results are written back as EX advances; EX output is forwarded to same-cycle issue reads.
module pipelined_regfile_alu #(
  parameter int DATA_W  = 8,
  parameter int NREGS   = 16,
  parameter int R0_ZERO = 1,
  localparam int AW     = $clog2(NREGS),
  localparam int SW     = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AW-1:0]     RA1,
  input  logic [AW-1:0]     RA2,
  input  logic [AW-1:0]     WA,
  input  logic              RegWrite,
  input  logic              ALUSrc,
  input  logic [DATA_W-1:0] external_data_in,
  input  logic [2:0]        ALUControl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ALUResult,
  output logic [3:0]        flags
);

  localparam int M = DATA_W - 1;

  logic [DATA_W-1:0] regs [NREGS];

  logic              ex_valid;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic [2:0]        ex_op;
  logic [AW-1:0]     ex_wa;
  logic              ex_we;

  logic              ex_adv;
  logic              issue;
  logic              ex_wr_ok;
  logic              fwd1;
  logic              fwd2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [DATA_W-1:0] srcb;

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   dif;
  logic [SW-1:0]     shamt;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              alu_v;
  logic [3:0]        alu_flags;

  assign ex_adv   = ex_valid && (!out_valid || out_ready);
  assign in_ready = !ex_valid || ex_adv;
  assign issue    = in_valid && in_ready;

  // A write aimed at a hardwired-zero R0 neither updates the array nor forwards.
  assign ex_wr_ok = ex_valid && ex_we && !((R0_ZERO != 0) && (ex_wa == '0));
  assign fwd1     = ex_wr_ok && (ex_wa == RA1);
  assign fwd2     = ex_wr_ok && (ex_wa == RA2);
  assign rd1      = fwd1 ? alu_res : regs[RA1];
  assign rd2      = fwd2 ? alu_res : regs[RA2];
  assign srcb     = ALUSrc ? external_data_in : rd2;

  always_comb begin
    sum     = {1'b0, ex_a} + {1'b0, ex_b};
    dif     = {1'b0, ex_a} + {1'b0, ~ex_b} + 1'b1;
    shamt   = ex_b[SW-1:0];
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (ex_op)
      3'b000: begin
        alu_res = sum[M:0];
        alu_c   = sum[DATA_W];
        alu_v   = (ex_a[M] == ex_b[M]) && (sum[M] != ex_a[M]);
      end
      3'b001: begin
        // Carry out of a + ~b + 1 is the inverted borrow.
        alu_res = dif[M:0];
        alu_c   = dif[DATA_W];
        alu_v   = (ex_a[M] != ex_b[M]) && (dif[M] != ex_a[M]);
      end
      3'b010:  alu_res = ex_a & ex_b;
      3'b011:  alu_res = ex_a | ex_b;
      3'b100:  alu_res = ex_a ^ ex_b;
      3'b101:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(ex_a) < $signed(ex_b))};
      3'b110:  alu_res = ex_a << shamt;
      default: alu_res = ex_a >> shamt;
    endcase
    alu_flags = {alu_res[M], (alu_res == '0), alu_c, alu_v};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (ex_adv && ex_wr_ok) begin
      regs[ex_wa] <= alu_res;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid <= 1'b0;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_op    <= '0;
      ex_wa    <= '0;
      ex_we    <= 1'b0;
    end else if (issue) begin
      ex_valid <= 1'b1;
      ex_a     <= rd1;
      ex_b     <= srcb;
      ex_op    <= ALUControl;
      ex_wa    <= WA;
      ex_we    <= RegWrite;
    end else if (ex_adv) begin
      ex_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      ALUResult <= '0;
      flags     <= '0;
    end else if (ex_adv) begin
      out_valid <= 1'b1;
      ALUResult <= alu_res;
      flags     <= alu_flags;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipelined_regfile_alu.sv
// tb/tb_pipelined_regfile_alu.sv - scoreboard bench with a serial-execution reference model
module tb_pipelined_regfile_alu;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] RA1;
  logic [3:0] RA2;
  logic [3:0] WA;
  logic       RegWrite;
  logic       ALUSrc;
  logic [7:0] external_data_in;
  logic [2:0] ALUControl;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] ALUResult;
  logic [3:0] flags;

  int total = 0;
  int bad = 0;
  int mregs [16];
  logic [11:0] exp_q [$];
  bit rand_mode = 0;

  pipelined_regfile_alu #(.DATA_W(8), .NREGS(16), .R0_ZERO(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .RA1(RA1), .RA2(RA2), .WA(WA), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
    .external_data_in(external_data_in), .ALUControl(ALUControl),
    .out_valid(out_valid), .out_ready(out_ready), .ALUResult(ALUResult), .flags(flags)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Reference ALU from the arithmetic definitions: returns {result, N, Z, C, V}.
  function automatic logic [11:0] ref_alu(input int op, input int a, input int b);
    int sa, sb, r, c, v, t;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    c = 0;
    v = 0;
    case (op)
      0: begin t = a + b; r = t % 256; c = (t > 255); t = sa + sb; v = (t > 127 || t < -128); end
      1: begin r = (a - b + 256) % 256; c = (a >= b); t = sa - sb; v = (t > 127 || t < -128); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (sa < sb) ? 1 : 0;
      6: r = (a << (b % 8)) % 256;
      default: r = a >> (b % 8);
    endcase
    return {r[7:0], (r > 127), (r == 0), c[0], v[0]};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: whenever a result is presented it must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out: got 0x%0h/%0h with nothing outstanding", ALUResult, flags);
      end else begin
        if ({ALUResult, flags} !== exp_q[0]) begin
          bad++;
          $display("FAIL result: got 0x%0h flags %b expected 0x%0h flags %b",
                   ALUResult, flags, exp_q[0][11:4], exp_q[0][3:0]);
        end
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (rand_mode) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic issue(input int op, input int ra1, input int ra2, input int wa,
                       input bit we, input bit src, input int imm);
    int a, b;
    logic [11:0] e;
    bit done;
    done = 0;
    in_valid = 1;
    ALUControl = op[2:0];
    RA1 = ra1[3:0];
    RA2 = ra2[3:0];
    WA = wa[3:0];
    RegWrite = we;
    ALUSrc = src;
    external_data_in = imm[7:0];
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        a = mregs[ra1];
        b = src ? imm : mregs[ra2];
        e = ref_alu(op, a, b);
        exp_q.push_back(e);
        if (we && wa != 0) mregs[wa] = e[11:4];
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: in_ready never rose for op %0d", op);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", ALUResult, 0);
    check("rst_flags", flags, 0);
    exp_q.delete();
    for (int i = 0; i < 16; i++) mregs[i] = 0;
    @(negedge clk);
    #1 reset = 0;
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    reset = 1;
    in_valid = 0;
    RA1 = 0; RA2 = 0; WA = 0;
    RegWrite = 0; ALUSrc = 0;
    external_data_in = 0; ALUControl = 0;
    out_ready = 1;
    do_reset();

    // Read of reset registers, with issue-to-out_valid latency of two edges.
    issue(0, 3, 5, 0, 0, 0, 0);
    check("lat_edge1", out_valid, 0);
    @(posedge clk);
    #1;
    check("lat_edge2", out_valid, 1);
    check("read_zero_res", ALUResult, 8'h00);
    check("read_zero_flags", flags, 4'b0100);
    drain();

    // Signed overflow on ADD, then a forwarded dependent read.
    issue(0, 0, 0, 1, 1, 1, 8'h7F);
    issue(0, 1, 0, 1, 1, 1, 8'h01);
    issue(0, 1, 0, 2, 1, 1, 8'h00);
    drain();
    check("r2_fwd_model", mregs[2], 8'h80);

    // SUB with borrow, then signed SLT of the negative result.
    issue(0, 0, 0, 1, 1, 1, 8'h05);
    issue(1, 1, 0, 1, 1, 1, 8'h07);
    issue(5, 1, 0, 3, 1, 1, 8'h01);
    issue(6, 1, 0, 4, 1, 1, 8'h00);
    issue(7, 1, 0, 5, 1, 1, 8'h03);
    drain();

    // Stall: out stage and EX fill, issue blocks, results stay stable, then drain in order.
    issue(0, 0, 0, 3, 1, 1, 8'h10);
    drain();
    out_ready = 0;
    issue(0, 3, 0, 3, 1, 1, 8'h01);
    issue(0, 3, 0, 3, 1, 1, 8'h01);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1 out_ready = 1;
    issue(0, 3, 0, 3, 1, 1, 8'h01);
    issue(3, 3, 0, 0, 0, 1, 8'h00);
    drain();
    check("stall_r3_model", mregs[3], 8'h13);

    // R0 is hardwired to zero but the result still appears.
    issue(0, 0, 0, 0, 1, 1, 8'h55);
    issue(3, 0, 0, 0, 0, 1, 8'h00);
    drain();

    // Reset while a write to R4 sits stalled in EX.
    out_ready = 0;
    issue(0, 0, 0, 5, 1, 1, 8'h11);
    issue(0, 0, 0, 4, 1, 1, 8'h44);
    do_reset();
    out_ready = 1;
    issue(3, 4, 0, 0, 0, 1, 8'h00);
    issue(3, 5, 0, 0, 0, 1, 8'h00);
    drain();

    // Random dependent traffic with random backpressure.
    rand_mode = 1;
    for (int n = 0; n < 400; n++) begin
      issue($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 255));
    end
    rand_mode = 0;
    @(posedge clk);
    #2 out_ready = 1;
    drain();
    for (int r = 0; r < 4; r++) issue(3, r, 0, 0, 0, 1, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_regfile_alu.md
PIPELINED_REGFILE_ALU -- requirements
Module: pipelined_regfile_alu

Interface
REQ-001 Parameter DATA_W, default 8, datapath and register width in bits (>=4).
REQ-002 Parameter NREGS, default 16, number of registers (power of two, >=2); AW = log2(NREGS).
REQ-003 Parameter R0_ZERO, default 1, when 1 register 0 reads as zero and ignores writes.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  issue request; in_ready  out  1  block accepts request this cycle.
REQ-007 RA1, RA2, WA  in  AW each  source A, source B, destination register addresses.
REQ-008 RegWrite  in  1  write result to WA; ALUSrc  in  1  0: SrcB=RD2, 1: SrcB=external_data_in.
REQ-009 external_data_in  in  DATA_W  immediate/external operand.
REQ-010 ALUControl  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed), 110 SHL, 111 SHR (logical).
REQ-011 out_valid  out  1  result held; out_ready  in  1  consumer accepts result.
REQ-012 ALUResult  out  DATA_W  registered result; flags  out  4  {N,Z,C,V} registered with result.

Function
REQ-013 Accept (issue) occurs on a rising edge where in_valid && in_ready; operands SrcA/SrcB, ALUControl, WA, RegWrite are captured into the EX stage.
REQ-014 RD1/RD2 read combinationally at issue; if EX stage valid, RegWrite set and EX WA equals RA1/RA2 (and not register 0 when R0_ZERO=1), the EX ALU output is forwarded instead of the array value.
REQ-015 EX stage advances into the OUT stage when out stage empty or out_ready=1; ALU result and flags register into ALUResult/flags and out_valid rises on that edge (latency: 2 edges issue-to-out_valid).
REQ-016 Register array write to WA happens on the same edge EX advances, exactly once per instruction, only when RegWrite=1.
REQ-017 in_ready = !EX_valid || EX advancing this cycle; in_ready is combinational with no dependence on in_valid.
REQ-018 out_valid stays high and ALUResult/flags stay stable until out_ready=1; out_valid clears on out_ready edge unless EX advances the same edge.
REQ-019 Full throughput: with out_ready held 1 the block accepts one request every cycle.
REQ-020 ADD/SUB modulo 2^DATA_W; C = carry out (ADD) or NOT borrow (SUB); V = signed overflow; C=V=0 for other ops.
REQ-021 SLT result is 1 zero-extended when SrcA<SrcB signed, else 0.
REQ-022 SHL/SHR shift SrcA by SrcB[log2(DATA_W)-1:0], zero fill; shift of 0 passes SrcA.
REQ-023 Z = (result==0); N = result MSB.
REQ-024 RegWrite to register 0 with R0_ZERO=1 is discarded; result still reaches ALUResult.
REQ-025 Back-to-back dependent issues (WA of instr k = RA of instr k+1) SHALL produce the same result as serial execution, including while stalled.

Reset
REQ-026 On reset assertion, immediately: all registers, EX stage, ALUResult, flags cleared to 0; out_valid=0; in_ready=1 after release.
REQ-027 Reset mid-operation discards in-flight instructions; no register write from them occurs.
REQ-028 First issue permitted on first rising edge after reset deasserts.

Verification
REQ-029 Reset, then read RA1=3,RA2=5,ADD,ALUSrc=0 -> ALUResult=0x00, flags Z=1, 2 edges after issue.
REQ-030 Issue R1=0x7F+imm 0x01 (ADD, ALUSrc=1, WA=1), next cycle R2=R1 ADD imm 0x00 -> results 0x80 then 0x80 (forwarded), V=1,N=1 on first.
REQ-031 SUB imm: R1=0x05 minus 0x07 -> 0xFE, N=1, C=0; SLT 0xFE vs 0x01 -> 0x01.
REQ-032 Hold out_ready=0 with three issues pending -> in_ready falls after EX fills, ALUResult stable; release -> results drain in order, each register written once.
REQ-033 Write 0x55 to R0 with R0_ZERO=1, then read R0 -> ALUResult 0x55 then 0x00.
REQ-034 Assert reset while EX valid with RegWrite to R4 -> out_valid=0, subsequent read of R4 returns 0x00.
